// File: rtl/fetch_pkg.sv
// Shared sizing and types for the instruction fetch buffer.
// Holds byte-lane geometry, count/offset widths and the shifter direction type.
// Imported by the fetch buffer top, its interface and the byte shifter.
package fetch_pkg;

    localparam int LINE_BYTES   = 16;
    localparam int BUF_BYTES    = 32;
    localparam int MAX_INSN_LEN = 15;

    // count spans 0..32, skip offset 0..15, shift amount 0..16
    localparam int CNT_W   = 6;
    localparam int OFF_W   = 4;
    localparam int SHAMT_W = 5;

    typedef logic [CNT_W-1:0]          cnt_t;
    typedef logic [OFF_W-1:0]          off_t;
    typedef logic [SHAMT_W-1:0]        shamt_t;
    typedef logic [8*LINE_BYTES-1:0]   line_t;
    typedef logic [8*BUF_BYTES-1:0]    store_t;

    typedef enum logic {
        SHIFT_DOWN = 1'b0,
        SHIFT_UP   = 1'b1
    } shift_dir_e;

endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch buffer bus: icache line input, redirect, and decode window output.
// master = icache/decode side driving requests; slave = the fetch buffer.
// Ports: line_valid/line_data/line_ready, flush_valid/flush_pc, stall_global, dec_take/dec_len/dec_valid/dec_bytes/dec_pc.
interface fetch_buffer_if;

    logic                   line_valid;
    fetch_pkg::line_t       line_data;
    logic                   line_ready;
    logic                   flush_valid;
    logic [31:0]            flush_pc;
    logic                   stall_global;
    logic                   dec_take;
    logic [3:0]             dec_len;
    logic                   dec_valid;
    fetch_pkg::line_t       dec_bytes;
    logic [31:0]            dec_pc;

    modport master (
        output line_valid, line_data, flush_valid, flush_pc,
               stall_global, dec_take, dec_len,
        input  line_ready, dec_valid, dec_bytes, dec_pc
    );

    modport slave (
        input  line_valid, line_data, flush_valid, flush_pc,
               stall_global, dec_take, dec_len,
        output line_ready, dec_valid, dec_bytes, dec_pc
    );

endinterface

// File: rtl/fetch_buffer_byte_shifter.sv
// Combinational byte shift of the 32-byte store, up or down by 0..16 bytes.
// Zero latency; no handshake (pure datapath).
// Ports: din (store), amt (bytes), dir (SHIFT_DOWN/SHIFT_UP), dout; vacated bytes fill with zero.
module byte_shifter
    import fetch_pkg::*;
(
    input  store_t     din,
    input  shamt_t     amt,
    input  shift_dir_e dir,
    output store_t     dout
);

    logic [SHAMT_W+2:0] bit_amt;

    always_comb begin
        bit_amt = {amt, 3'b000};
        dout    = '0;
        if (dir == SHIFT_DOWN) begin
            dout = din >> bit_amt;
        end else begin
            dout = din << bit_amt;
        end
    end

endmodule

// File: rtl/fetch_buffer.sv
// Two-line byte queue that aligns icache lines into a 16-byte decode window.
// Latency: an accepted line is visible on the window one cycle later.
// Backpressure: line_ready while <=16 bytes held; decode consumes only when a full window exists.
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    fetch_buffer_if.slave  bus
);

    localparam cnt_t LINE_CNT = cnt_t'(LINE_BYTES);

    store_t      store_q, store_d;
    cnt_t        count_q, count_d;
    off_t        skip_q,  skip_d;
    logic [31:0] pc_q,    pc_d;

    logic   accept;
    logic   consume;
    cnt_t   len_cnt;
    cnt_t   after_consume;
    store_t kept;
    store_t aligned;
    store_t placed;

    // Bytes at positions >= count are always held at zero, so the window
    // can be driven straight from storage without masking.
    assign bus.line_ready = (count_q <= LINE_CNT);
    assign bus.dec_valid  = (count_q >= LINE_CNT);
    assign bus.dec_bytes  = store_q[8*LINE_BYTES-1:0];
    assign bus.dec_pc     = pc_q;

    always_comb begin
        accept  = bus.line_valid & bus.line_ready & ~bus.flush_valid;
        consume = bus.dec_valid & bus.dec_take & ~bus.stall_global &
                  (bus.dec_len != 4'd0) & ~bus.flush_valid;
        len_cnt       = consume ? cnt_t'(bus.dec_len) : '0;
        after_consume = count_q - len_cnt;
    end

    // Drop consumed bytes off the bottom of the store.
    byte_shifter u_consume (
        .din  (store_q),
        .amt  (shamt_t'(len_cnt)),
        .dir  (SHIFT_DOWN),
        .dout (kept)
    );

    // Strip the leading skip bytes of a line entered mid-line after a redirect.
    byte_shifter u_align (
        .din  ({{(8*(BUF_BYTES-LINE_BYTES)){1'b0}}, bus.line_data}),
        .amt  (shamt_t'(skip_q)),
        .dir  (SHIFT_DOWN),
        .dout (aligned)
    );

    // Append after whatever survives this cycle's consume; accept only
    // happens when count <= 16, so the offset fits the shifter range.
    byte_shifter u_place (
        .din  (aligned),
        .amt  (after_consume[SHAMT_W-1:0]),
        .dir  (SHIFT_UP),
        .dout (placed)
    );

    always_comb begin
        store_d = kept;
        count_d = after_consume;
        skip_d  = skip_q;
        pc_d    = pc_q + 32'(len_cnt);
        if (accept) begin
            store_d = kept | placed;
            count_d = after_consume + (LINE_CNT - cnt_t'(skip_q));
            skip_d  = '0;
        end
        if (bus.flush_valid) begin
            store_d = '0;
            count_d = '0;
            skip_d  = bus.flush_pc[OFF_W-1:0];
            pc_d    = bus.flush_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            store_q <= '0;
            count_q <= '0;
            skip_q  <= '0;
            pc_q    <= '0;
        end else begin
            store_q <= store_d;
            count_q <= count_d;
            skip_q  <= skip_d;
            pc_q    <= pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: line append, consume, flush, stall and async reset.
// Expected windows are built from byte-sequence helpers with hand-derived bases and lengths.
// Ports driven through a fetch_buffer_if instance.
module tb_fetch_buffer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fetch_buffer_if bus ();

    fetch_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Window whose byte k is base+k for k < n, zero above.
    function automatic logic [127:0] mk_seq(input logic [7:0] base, input int n);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < n; k++) r[8*k +: 8] = base + 8'(k);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.line_valid   = 1'b0;
        bus.flush_valid  = 1'b0;
        bus.stall_global = 1'b0;
        bus.dec_take     = 1'b0;
        bus.dec_len      = 4'd0;
    endtask

    task automatic chk_state(input string tag, input int cnt, input logic [31:0] pc,
                             input logic [127:0] win);
        chk({tag, "_count"}, 128'(dut.count_q), 128'(cnt));
        chk({tag, "_pc"},    128'(bus.dec_pc), 128'(pc));
        chk({tag, "_bytes"}, bus.dec_bytes, win);
        chk({tag, "_valid"}, 128'(bus.dec_valid), 128'(cnt >= 16));
        chk({tag, "_ready"}, 128'(bus.line_ready), 128'(cnt <= 16));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle_inputs();
        bus.line_data = '0;
        bus.flush_pc  = '0;

        // Reset state before any clock edge.
        #1;
        chk_state("reset", 0, 32'h0, '0);
        step();
        rst = 1'b0;

        // First line 00..0F.
        bus.line_valid = 1'b1;
        bus.line_data  = mk_seq(8'h00, 16);
        step();
        bus.line_valid = 1'b0;
        chk_state("line0", 16, 32'h0, mk_seq(8'h00, 16));

        // Consume 3.
        bus.dec_take = 1'b1;
        bus.dec_len  = 4'd3;
        step();
        bus.dec_take = 1'b0;
        chk_state("take3", 13, 32'h3, mk_seq(8'h03, 13));
        chk("take3_byte0", 128'(bus.dec_bytes[7:0]), 128'(8'h03));

        // Second line 10..1F appended after the 13 remaining bytes.
        bus.line_valid = 1'b1;
        bus.line_data  = mk_seq(8'h10, 16);
        step();
        chk_state("line1", 29, 32'h3, mk_seq(8'h03, 16));

        // line_valid held while full; consume 15 frees room but the line waits.
        bus.line_data = mk_seq(8'h20, 16);
        bus.dec_take  = 1'b1;
        bus.dec_len   = 4'd15;
        step();
        bus.dec_take  = 1'b0;
        chk_state("take15", 14, 32'h12, mk_seq(8'h12, 14));

        // Held line now accepted.
        step();
        chk_state("line2", 30, 32'h12, mk_seq(8'h12, 16));

        // Consume 14 while the still-presented line is refused.
        bus.line_data = mk_seq(8'h30, 16);
        bus.dec_take  = 1'b1;
        bus.dec_len   = 4'd14;
        step();
        chk_state("take14", 16, 32'h20, mk_seq(8'h20, 16));

        // Simultaneous accept and consume: 16 + 16 - 5.
        bus.dec_len = 4'd5;
        step();
        chk_state("acc_con", 27, 32'h25, mk_seq(8'h25, 16));

        // Flush beats a presented line and a take.
        bus.flush_valid = 1'b1;
        bus.flush_pc    = 32'h0000_1005;
        step();
        idle_inputs();
        chk_state("flush1", 0, 32'h1005, '0);

        // Line after redirect: skip 5 leading bytes.
        bus.line_valid = 1'b1;
        bus.line_data  = mk_seq(8'hA0, 16);
        step();
        chk_state("lineA", 11, 32'h1005, mk_seq(8'hA5, 11));
        chk("lineA_byte0", 128'(bus.dec_bytes[7:0]), 128'(8'hA5));

        // Next line lands with skip already cleared.
        bus.line_data = mk_seq(8'hB0, 16);
        step();
        bus.line_valid = 1'b0;
        chk_state("lineB", 27, 32'h1005, mk_seq(8'hA5, 16));

        // Stall blocks consumption.
        bus.stall_global = 1'b1;
        bus.dec_take     = 1'b1;
        bus.dec_len      = 4'd5;
        step();
        chk_state("stall", 27, 32'h1005, mk_seq(8'hA5, 16));

        // Zero length is ignored.
        bus.stall_global = 1'b0;
        bus.dec_len      = 4'd0;
        step();
        idle_inputs();
        chk_state("len0", 27, 32'h1005, mk_seq(8'hA5, 16));

        // Flush with a line in the same cycle drops the line.
        bus.flush_valid = 1'b1;
        bus.flush_pc    = 32'h0000_2000;
        bus.line_valid  = 1'b1;
        bus.line_data   = mk_seq(8'hC0, 16);
        step();
        idle_inputs();
        chk_state("flush2", 0, 32'h2000, '0);
        step();
        chk_state("flush2_idle", 0, 32'h2000, '0);

        // Build count 20 from a mid-line redirect, then reset between edges.
        bus.flush_valid = 1'b1;
        bus.flush_pc    = 32'h0000_300C;
        step();
        bus.flush_valid = 1'b0;
        bus.line_valid  = 1'b1;
        bus.line_data   = mk_seq(8'h00, 16);
        step();
        chk_state("lineC", 4, 32'h300C, mk_seq(8'h0C, 4));
        bus.line_data = mk_seq(8'h10, 16);
        step();
        bus.line_valid = 1'b0;
        chk_state("lineD", 20, 32'h300C, mk_seq(8'h0C, 16));

        #2;
        rst = 1'b1;
        #1;
        chk_state("async_rst", 0, 32'h0, '0);
        #1;
        rst = 1'b0;
        step();
        chk_state("post_rst", 0, 32'h0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have a single clock; reset is asynchronous and active-high.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 line_valid  in  1  icache line available this cycle.
REQ-005 line_data  in  128  16-byte aligned fetch line; byte k = bits [8k+7:8k].
REQ-006 line_ready  out  1  buffer will accept a line this cycle.
REQ-007 flush_valid  in  1  redirect (branch/exception) request.
REQ-008 flush_pc  in  32  redirect target PC.
REQ-009 stall_global  in  1  pipeline stall; blocks consumption.
REQ-010 dec_take  in  1  decode consumes bytes this cycle.
REQ-011 dec_len  in  4  bytes consumed, legal 1..15.
REQ-012 dec_valid  out  1  full 16-byte window available to decode.
REQ-013 dec_bytes  out  128  window; byte 0 is the byte at dec_pc.
REQ-014 dec_pc  out  32  PC of window byte 0.

Function
REQ-015 SHALL hold up to 32 bytes (two lines) and track byte count (0..32), skip offset (0..15) and dec_pc.
REQ-016 line_ready SHALL be combinational: 1 iff count <= 16.
REQ-017 Line accept = line_valid & line_ready & !flush_valid; accepted bytes skip..15 are appended after existing bytes, count += 16 - skip, and skip is then cleared.
REQ-018 dec_valid SHALL be 1 iff count >= 16.
REQ-019 Consume = dec_valid & dec_take & !stall_global & (1 <= dec_len <= 15); the window shifts down by dec_len bytes, count -= dec_len, dec_pc += dec_len (mod 2^32).
REQ-020 dec_len = 0 SHALL be ignored (no state change).
REQ-021 Simultaneous accept and consume SHALL yield count' = count + (16 - skip) - dec_len in one cycle.
REQ-022 flush_valid SHALL take priority over accept and consume: count := 0, skip := flush_pc[3:0], dec_pc := flush_pc; any line presented that cycle is discarded.
REQ-023 dec_bytes bytes at positions >= count SHALL read as 8'h00.
REQ-024 Latency: an accepted line SHALL be visible on dec_bytes/dec_valid the next cycle; there is no combinational path from line_data to dec_bytes.
REQ-025 The state update SHALL be registered on the rising edge of clk; outputs SHALL depend only on state (line_ready and dec_valid from count).

Reset
REQ-026 While rst=1, regardless of clk: count=0, skip=0, dec_pc=32'h0, storage=0; hence dec_valid=0, line_ready=1, dec_bytes=0.
REQ-027 Reset asserted mid-operation SHALL discard all buffered bytes with no partial update.

Structure
REQ-028 Package fetch_pkg SHALL hold LINE_BYTES=16, BUF_BYTES=32, MAX_INSN_LEN=15 and the count/offset widths.
REQ-029 One sub-module, byte_shifter (combinational variable byte-shift of the 32-byte store by 0..16), SHALL be used for both append and consume alignment.

Verification
REQ-030 Reset; line bytes 00..0F -> next cycle dec_valid=1, dec_pc=0, byte0=00; take len 3 -> dec_pc=3, byte0=03, count=13, dec_valid=0.
REQ-031 Continue with line 10..1F -> count=29, dec_bytes bytes 03..12, line_ready=0.
REQ-032 count=29, line_valid held; take len 15 -> count=14, line_ready=1; line accepted the next cycle -> count=30.
REQ-033 flush_pc=32'h0000_1005, then line A0..AF -> count=11, dec_valid=0, dec_pc=32'h1005, byte0=A5, bytes 11..15 = 00.
REQ-034 stall_global=1 with dec_take=1, len=5 -> dec_pc, count and dec_bytes unchanged; flush and line_valid in the same cycle -> count=0 and the line is dropped.
REQ-035 count=20, rst pulsed between clock edges -> dec_valid=0, line_ready=1, dec_pc=0 immediately, before the next edge.
